// File: rtl/oh_pwrgate_pkg.sv
// Shared types and sizing helpers for the power-gate sequencing controller.
package oh_pwrgate_pkg;

    typedef enum logic [2:0] {
        PG_OFF      = 3'd0,
        PG_RAMP_UP  = 3'd1,
        PG_WAIT_ACK = 3'd2,
        PG_REL_RST  = 3'd3,
        PG_ON       = 3'd4,
        PG_SHUT     = 3'd5,
        PG_RAMP_DN  = 3'd6,
        PG_ERR      = 3'd7
    } pg_state_t;

    // One counter serves both the step delay and the acknowledge timeout.
    function automatic int cnt_width(input int stage_dly, input int timeout);
        int longest;
        longest = (stage_dly > timeout) ? stage_dly : timeout;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/oh_pwrgate_if.sv
// Request/acknowledge and switch-drive bundle between the always-on side and the gated domain.
interface oh_pwrgate_if
    import oh_pwrgate_pkg::*;
#(
    parameter int N = 4
);
    logic         pwr_req;
    logic         pwr_ack;
    logic [N-1:0] psw_n;
    logic         iso;
    logic         domain_reset;
    logic         pwr_on;
    logic         busy;
    logic         err;

    modport master (
        output pwr_req, pwr_ack,
        input  psw_n, iso, domain_reset, pwr_on, busy, err
    );

    modport slave (
        input  pwr_req, pwr_ack,
        output psw_n, iso, domain_reset, pwr_on, busy, err
    );
endinterface

// File: rtl/oh_dsync.sv
// Two-flop synchronizer bringing the switch-chain acknowledge into the clk domain.
module oh_dsync
    import oh_pwrgate_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/oh_pwrgate_ctrl.sv
// Staggered PMOS header sequencer: ramps switches, waits for the chain ack,
// then releases isolation and domain reset; reverses on power-down.
module oh_pwrgate_ctrl
    import oh_pwrgate_pkg::*;
#(
    parameter int N        = 4,
    parameter int STAGEDLY = 8,
    parameter int TIMEOUT  = 64
)
(
    input  logic         clk,
    input  logic         reset,
    oh_pwrgate_if.slave  bus
);
    localparam int CW = cnt_width(STAGEDLY, TIMEOUT);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    localparam logic [CW-1:0] STEP_LAST = CW'(STAGEDLY - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT - 1);
    localparam logic [IW-1:0] IDX_TOP   = IW'(N - 1);
    localparam logic [N-1:0]  ALL_OFF   = '1;

    localparam logic [2:0] S_OFF      = PG_OFF;
    localparam logic [2:0] S_RAMP_UP  = PG_RAMP_UP;
    localparam logic [2:0] S_WAIT_ACK = PG_WAIT_ACK;
    localparam logic [2:0] S_REL_RST  = PG_REL_RST;
    localparam logic [2:0] S_ON       = PG_ON;
    localparam logic [2:0] S_SHUT     = PG_SHUT;
    localparam logic [2:0] S_RAMP_DN  = PG_RAMP_DN;
    localparam logic [2:0] S_ERR      = PG_ERR;

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic [N-1:0]  psw_n;
    logic          iso, domain_reset, pwr_on, busy, err;
    logic          ack_s;

    oh_dsync u_ack_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.pwr_ack),
        .q     (ack_s)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_OFF;
            cnt          <= '0;
            idx          <= '0;
            psw_n        <= ALL_OFF;
            iso          <= 1'b1;
            domain_reset <= 1'b1;
            pwr_on       <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
        end else begin
            cnt <= cnt + CW'(1);
            case (state)
                S_OFF: if (bus.pwr_req) begin
                    state <= S_RAMP_UP;
                    psw_n <= ALL_OFF << 1;
                    cnt   <= '0;
                    idx   <= '0;
                    busy  <= 1'b1;
                end
                S_RAMP_UP: if (cnt == STEP_LAST) begin
                    cnt <= '0;
                    if (idx == IDX_TOP) begin
                        state <= S_WAIT_ACK;
                    end else begin
                        psw_n <= psw_n & ~(N'(2) << idx);
                        idx   <= idx + IW'(1);
                    end
                end
                S_WAIT_ACK: begin
                    if (ack_s) begin
                        state <= S_REL_RST;
                        iso   <= 1'b0;
                        cnt   <= '0;
                    end else if (cnt == TO_LAST) begin
                        state <= S_ERR;
                        psw_n <= ALL_OFF;
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end
                end
                S_REL_RST: if (cnt == STEP_LAST) begin
                    state        <= S_ON;
                    domain_reset <= 1'b0;
                    pwr_on       <= 1'b1;
                    busy         <= 1'b0;
                    cnt          <= '0;
                end
                S_ON: if (!bus.pwr_req) begin
                    state        <= S_SHUT;
                    iso          <= 1'b1;
                    domain_reset <= 1'b1;
                    pwr_on       <= 1'b0;
                    busy         <= 1'b1;
                    cnt          <= '0;
                end
                // A single-segment array has nothing left to stagger after the top bit.
                S_SHUT: if (cnt == STEP_LAST) begin
                    psw_n <= psw_n | (N'(1) << IDX_TOP);
                    idx   <= IDX_TOP;
                    cnt   <= '0;
                    state <= (N == 1) ? S_OFF : S_RAMP_DN;
                    busy  <= (N != 1);
                end
                S_RAMP_DN: if (cnt == STEP_LAST) begin
                    psw_n <= psw_n | (N'(1) << (idx - IW'(1)));
                    idx   <= idx - IW'(1);
                    cnt   <= '0;
                    if (idx == IW'(1)) begin
                        state <= S_OFF;
                        busy  <= 1'b0;
                    end
                end
                S_ERR: if (!bus.pwr_req) begin
                    state <= S_OFF;
                    err   <= 1'b0;
                    cnt   <= '0;
                end
                default: state <= S_OFF;
            endcase
        end
    end

    assign bus.psw_n        = psw_n;
    assign bus.iso          = iso;
    assign bus.domain_reset = domain_reset;
    assign bus.pwr_on       = pwr_on;
    assign bus.busy         = busy;
    assign bus.err          = err;

endmodule

// File: tb/tb_oh_pwrgate_ctrl.sv
// Bench for oh_pwrgate_ctrl: directed sequences from the test plan plus random
// request/ack/reset traffic, all checked against an elapsed-time phase model.
module tb_oh_pwrgate_ctrl;
    import oh_pwrgate_pkg::*;

    localparam int N = 4;
    localparam int S = 8;
    localparam int T = 64;

    localparam int P_OFF  = 0;
    localparam int P_UP   = 1;
    localparam int P_WAIT = 2;
    localparam int P_REL  = 3;
    localparam int P_ON   = 4;
    localparam int P_DOWN = 5;
    localparam int P_ERR  = 6;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic pwr_req = 1'b0;
    logic pwr_ack = 1'b0;

    int total = 0;
    int bad = 0;
    int ec = 0;

    int ph = P_OFF;
    int t = 0;
    logic a1 = 1'b0;
    logic a2 = 1'b0;

    always #5 clk = ~clk;

    oh_pwrgate_if #(.N(N)) bus ();
    assign bus.pwr_req = pwr_req;
    assign bus.pwr_ack = pwr_ack;

    oh_pwrgate_ctrl #(.N(N), .STAGEDLY(S), .TIMEOUT(T)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    wire [8:0] outs = {bus.psw_n, bus.iso, bus.domain_reset, bus.pwr_on, bus.busy, bus.err};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs seen at this edge are the tb drive values; ack reaches the FSM two edges late.
    task automatic model_edge();
        logic ack_seen;
        int t1;
        if (reset) begin
            ph = P_OFF; t = 0; a1 = 1'b0; a2 = 1'b0;
        end else begin
            ack_seen = a2;
            a2 = a1;
            a1 = pwr_ack;
            t1 = t + 1;
            case (ph)
                P_OFF:  if (pwr_req) begin ph = P_UP; t = 0; end
                P_UP:   if (t1 == N * S) begin ph = P_WAIT; t = 0; end else t = t1;
                P_WAIT: if (ack_seen) begin ph = P_REL; t = 0; end
                        else if (t1 == T) begin ph = P_ERR; t = 0; end
                        else t = t1;
                P_REL:  if (t1 == S) begin ph = P_ON; t = 0; end else t = t1;
                P_ON:   if (!pwr_req) begin ph = P_DOWN; t = 0; end
                P_DOWN: if (t1 == N * S) begin ph = P_OFF; t = 0; end else t = t1;
                P_ERR:  if (!pwr_req) begin ph = P_OFF; t = 0; end
                default: ph = P_OFF;
            endcase
        end
    endtask

    function automatic logic [8:0] model_out();
        int full;
        int n_on;
        int n_off;
        logic [3:0] sw;
        full = (1 << N) - 1;
        case (ph)
            P_UP: begin
                n_on = t / S + 1;
                if (n_on > N) n_on = N;
                sw = 4'(full & ~((1 << n_on) - 1));
                return {sw, 5'b11010};
            end
            P_WAIT: return {4'b0000, 5'b11010};
            P_REL:  return {4'b0000, 5'b01010};
            P_ON:   return {4'b0000, 5'b00100};
            P_DOWN: begin
                n_off = t / S;
                sw = 4'(full & ~((1 << (N - n_off)) - 1));
                return {sw, 5'b11010};
            end
            P_ERR:  return {4'b1111, 5'b11001};
            default: return {4'b1111, 5'b11000};
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        ec++;
        model_edge();
        @(negedge clk);
        chk("model", 32'(outs), 32'(model_out()));
    endtask

    task automatic run_to(input int e);
        while (ec < e) step();
    endtask

    task automatic restart();
        reset = 1'b1;
        ec = 0;
        run_to(3);
        reset = 1'b0;
    endtask

    initial begin
        // reset values and power-up / power-down timeline
        pwr_req = 1'b0; pwr_ack = 1'b0;
        restart();
        chk("reset_vals", 32'(outs), 32'(9'b1111_11000));
        run_to(9);   pwr_req = 1'b1;
        run_to(10);  chk("up_e10", 32'(bus.psw_n), 32'(4'b1110));
        run_to(18);  chk("up_e18", 32'(bus.psw_n), 32'(4'b1100));
        run_to(26);  chk("up_e26", 32'(bus.psw_n), 32'(4'b1000));
        run_to(34);  chk("up_e34", 32'(bus.psw_n), 32'(4'b0000));
        run_to(44);  pwr_ack = 1'b1;
        run_to(46);  chk("iso_e46", 32'(bus.iso), 32'(1));
        run_to(47);  chk("iso_e47", 32'(bus.iso), 32'(0));
        run_to(54);  chk("on_e54", 32'(bus.pwr_on), 32'(0));
                     chk("busy_e54", 32'(bus.busy), 32'(1));
        run_to(55);  chk("on_e55", 32'({bus.domain_reset, bus.pwr_on, bus.busy}), 32'(3'b010));
        run_to(99);  pwr_req = 1'b0;
        run_to(100); chk("dn_e100", 32'({bus.iso, bus.domain_reset, bus.pwr_on}), 32'(3'b110));
        run_to(108); chk("dn_e108", 32'(bus.psw_n), 32'(4'b1000));
        run_to(116); chk("dn_e116", 32'(bus.psw_n), 32'(4'b1100));
        run_to(124); chk("dn_e124", 32'(bus.psw_n), 32'(4'b1110));
        run_to(132); chk("dn_e132", 32'({bus.psw_n, bus.busy}), 32'(5'b11110));

        // acknowledge timeout into ERR, then release
        pwr_ack = 1'b0;
        restart();
        run_to(9);   pwr_req = 1'b1;
        run_to(105); chk("to_e105", 32'(bus.err), 32'(0));
        run_to(106); chk("to_e106", 32'({bus.psw_n, bus.err}), 32'(5'b11111));
        run_to(110); chk("err_hold", 32'(bus.err), 32'(1));
        pwr_req = 1'b0;
        run_to(111); chk("err_clr", 32'({bus.err, bus.busy, bus.psw_n}), 32'(6'b001111));

        // request glitch during ramp-up, then low on the first ON cycle
        restart();
        pwr_ack = 1'b1;
        run_to(9);   pwr_req = 1'b1;
        run_to(14);  pwr_req = 1'b0;
        run_to(16);  pwr_req = 1'b1;
        run_to(40);  pwr_req = 1'b0;
        run_to(50);  chk("gl_busy", 32'(bus.busy), 32'(1));
        run_to(51);  chk("gl_on", 32'(bus.pwr_on), 32'(1));
        run_to(52);  chk("gl_shut", 32'({bus.pwr_on, bus.iso, bus.busy}), 32'(3'b011));

        // reset in the middle of ramp-up turns every switch off at once
        pwr_ack = 1'b0;
        restart();
        run_to(9);   pwr_req = 1'b1;
        run_to(19);  reset = 1'b1;
        run_to(20);  chk("rst_mid", 32'({bus.psw_n, bus.busy}), 32'(5'b11110));
        reset = 1'b0; pwr_req = 1'b0;
        run_to(30);  chk("rst_stay", 32'(bus.psw_n), 32'(4'b1111));

        // random request / ack / reset traffic against the model
        restart();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 199) == 0) pwr_req = ~pwr_req;
            if ($urandom_range(0, 29) == 0) pwr_ack = ~pwr_ack;
            reset = ($urandom_range(0, 1999) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
